// File: rtl/lstm_cell_sequencer.sv
// lstm_cell_sequencer: sequences LSTM timesteps for the lstm_cell datapath.
// Each timestep goes through clear, accumulate beats, activation drain and
// capture. The FSM state is kept in the enum signal `state` so checkers can
// observe it.
// Handshake: i_start is a level request, taken only in IDLE (and only if
// i_abort is low). o_done and o_capture are single-cycle pulses with no
// back-pressure.
module lstm_cell_sequencer #(
    parameter int WIDTH = 32,
    parameter int N_X   = 2,
    parameter int N_H   = 1,
    parameter int LAT   = 2,
    parameter int IDX_W = 8,
    parameter int T_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [T_W-1:0]   i_seq_len,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_cell_clr,
    output logic             o_acc_x,
    output logic             o_acc_h,
    output logic [IDX_W-1:0] o_x_addr,
    output logic [IDX_W-1:0] o_h_addr,
    output logic [T_W-1:0]   o_t,
    output logic             o_first,
    output logic             o_capture
);

    // Number of accumulate beats per timestep.
    localparam int K      = (N_X > N_H) ? N_X : N_H;
    // The drain counter needs at least one bit, even when LAT is 0.
    localparam int DW     = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int D_LAST = (LAT > 0) ? LAT - 1 : 0;

    // Elaboration-time sanity check on the parameter set.
    if (WIDTH < 1 || N_X < 1 || N_H < 1 || LAT < 0 || IDX_W < 1 || T_W < 1) begin : g_param_check
        $error("lstm_cell_sequencer: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_ACC     = 3'd2,
        S_DRAIN   = 3'd3,
        S_CAPTURE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] k;
    logic [DW-1:0]    d;
    logic [T_W-1:0]   t;
    logic [T_W-1:0]   len;
    logic             last_beat;
    logic             last_drain;
    logic             last_step;

    assign last_beat  = (k == IDX_W'(K - 1));
    assign last_drain = (d == DW'(D_LAST));
    assign last_step  = (t == len - T_W'(1));

    // State register plus the beat, drain and timestep counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            k     <= '0;
            d     <= '0;
            t     <= '0;
            len   <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    // Any accepted start (including len 0) restarts the timestep index.
                    if (state_next != S_IDLE) begin
                        len <= i_seq_len;
                        t   <= '0;
                    end
                end
                S_CLEAR: begin
                    k <= '0;
                    d <= '0;
                end
                S_ACC: begin
                    k <= last_beat ? '0 : k + IDX_W'(1);
                end
                S_DRAIN: begin
                    d <= d + DW'(1);
                end
                S_CAPTURE: begin
                    if (state_next == S_CLEAR) begin
                        t <= t + T_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state decode; abort overrides every transition, including a start.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_next = (i_seq_len != '0) ? S_CLEAR : S_DONE;
                end
            end
            S_CLEAR:   state_next = S_ACC;
            S_ACC: begin
                if (last_beat) begin
                    state_next = (LAT == 0) ? S_CAPTURE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_drain) begin
                    state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: state_next = last_step ? S_DONE : S_CLEAR;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
        if (i_abort) begin
            state_next = S_IDLE;
        end
    end

    // Moore output decode from the registered state and counters.
    always_comb begin
        o_busy     = 1'b0;
        o_done     = 1'b0;
        o_cell_clr = 1'b0;
        o_acc_x    = 1'b0;
        o_acc_h    = 1'b0;
        o_x_addr   = '0;
        o_h_addr   = '0;
        o_capture  = 1'b0;
        o_t        = t;
        case (state)
            S_CLEAR: begin
                o_busy     = 1'b1;
                o_cell_clr = 1'b1;
            end
            S_ACC: begin
                o_busy   = 1'b1;
                o_acc_x  = ({1'b0, k} < (IDX_W + 1)'(N_X));
                o_acc_h  = ({1'b0, k} < (IDX_W + 1)'(N_H));
                o_x_addr = o_acc_x ? k : '0;
                o_h_addr = o_acc_h ? k : '0;
            end
            S_DRAIN: begin
                o_busy = 1'b1;
            end
            S_CAPTURE: begin
                o_busy    = 1'b1;
                o_capture = 1'b1;
            end
            S_DONE: begin
                o_done = 1'b1;
            end
            default: begin
            end
        endcase
        o_first = o_busy && (t == '0);
    end

endmodule

// File: tb/tb_lstm_cell_sequencer.sv
// Bench for lstm_cell_sequencer: two instances (default parameters and
// N_X=1/N_H=3/LAT=0) share one stimulus stream. Every cycle is compared with
// a timeline model derived from the per-timestep cycle budget, and a
// scenario table checks capture counts and done cycles.
module tb_lstm_cell_sequencer;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       clr;
        logic       ax;
        logic       ah;
        logic       cap;
        logic       first;
        logic [7:0] xa;
        logic [7:0] ha;
        logic [7:0] t;
    } obs_t;

    typedef struct {
        int len;
        int abort_c;
        int caps_a;
        int done_a;
        int caps_b;
        int done_b;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] seq_len = '0;

    logic       a_busy, a_done, a_clr, a_ax, a_ah, a_cap, a_first;
    logic [7:0] a_xa, a_ha, a_t;
    logic       b_busy, b_done, b_clr, b_ax, b_ah, b_cap, b_first;
    logic [7:0] b_xa, b_ha, b_t;
    obs_t       oa;
    obs_t       ob;

    int total = 0;
    int bad = 0;

    assign oa = {a_busy, a_done, a_clr, a_ax, a_ah, a_cap, a_first, a_xa, a_ha, a_t};
    assign ob = {b_busy, b_done, b_clr, b_ax, b_ah, b_cap, b_first, b_xa, b_ha, b_t};

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    lstm_cell_sequencer dut_a (
        .clk(clk), .rst(rst), .i_start(start), .i_seq_len(seq_len), .i_abort(abort),
        .o_busy(a_busy), .o_done(a_done), .o_cell_clr(a_clr), .o_acc_x(a_ax),
        .o_acc_h(a_ah), .o_x_addr(a_xa), .o_h_addr(a_ha), .o_t(a_t),
        .o_first(a_first), .o_capture(a_cap)
    );

    lstm_cell_sequencer #(.N_X(1), .N_H(3), .LAT(0)) dut_b (
        .clk(clk), .rst(rst), .i_start(start), .i_seq_len(seq_len), .i_abort(abort),
        .o_busy(b_busy), .o_done(b_done), .o_cell_clr(b_clr), .o_acc_x(b_ax),
        .o_acc_h(b_ah), .o_x_addr(b_xa), .o_h_addr(b_ha), .o_t(b_t),
        .o_first(b_first), .o_capture(b_cap)
    );

    // Cycle in which o_done shows, counting the start cycle as 0.
    function automatic int done_cycle(int nx, int nh, int lat, int len);
        int k;
        k = (nx > nh) ? nx : nh;
        return (len == 0) ? 1 : len * (k + lat + 2) + 1;
    endfunction

    // Reference timeline: each timestep is 1 clear + K beats + LAT drain + 1 capture.
    function automatic obs_t model(int nx, int nh, int lat, int len, int abort_c, int c,
                                   output bit tv);
        obs_t e;
        int   k, p, step, ph, b, dc;
        e  = '0;
        tv = 1'b1;
        k  = (nx > nh) ? nx : nh;
        p  = k + lat + 2;
        dc = done_cycle(nx, nh, lat, len);
        if (abort_c >= 0 && c > abort_c) begin
            tv = 1'b0;
        end else if (c >= 1 && len > 0 && c <= len * p) begin
            step    = (c - 1) / p;
            ph      = (c - 1) % p;
            e.busy  = 1'b1;
            e.t     = 8'(step);
            e.first = (step == 0);
            if (ph == 0) begin
                e.clr = 1'b1;
            end else if (ph <= k) begin
                b    = ph - 1;
                e.ax = (b < nx);
                e.ah = (b < nh);
                e.xa = e.ax ? 8'(b) : 8'd0;
                e.ha = e.ah ? 8'(b) : 8'd0;
            end else if (ph == p - 1) begin
                e.cap = 1'b1;
            end
        end else if (c >= dc) begin
            e.done = (c == dc);
            e.t    = (len > 0) ? 8'(len - 1) : 8'd0;
        end else begin
            tv = 1'b0;
        end
        return e;
    endfunction

    // scoreboard: compare observed outputs with expected, o_t masked when unknown
    task automatic check_obs(input string name, input int c, input obs_t got, input obs_t exp,
                             input bit tv);
        total++;
        if (!tv) begin
            got.t = '0;
            exp.t = '0;
        end
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", name, c, got, exp);
        end
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // driver: one start at cycle 0, optional abort, optional ignored starts while busy
    task automatic run_scen(input int len, input int abort_c, input bit rnd,
                            output int caps_a, output int done_a,
                            output int caps_b, output int done_b);
        int   da, db, last, lim;
        bit   tva, tvb;
        obs_t ea, eb;
        da     = done_cycle(2, 1, 2, len);
        db     = done_cycle(1, 3, 0, len);
        lim    = (da < db) ? da : db;
        last   = (abort_c >= 0) ? abort_c + 1 : ((da > db) ? da : db) + 1;
        caps_a = 0;
        caps_b = 0;
        done_a = -1;
        done_b = -1;
        for (int c = 0; c <= last; c++) begin
            ea = model(2, 1, 2, len, abort_c, c, tva);
            eb = model(1, 3, 0, len, abort_c, c, tvb);
            check_obs("dut_a", c, oa, ea, tva);
            check_obs("dut_b", c, ob, eb, tvb);
            if (oa.cap) caps_a++;
            if (ob.cap) caps_b++;
            if (oa.done && done_a < 0) done_a = c;
            if (ob.done && done_b < 0) done_b = c;
            start   = (c == 0) ||
                      (rnd && c <= lim && (abort_c < 0 || c <= abort_c) &&
                       $urandom_range(0, 2) == 0);
            seq_len = (c == 0) ? 8'(len) : 8'($urandom_range(0, 255));
            abort   = (c == abort_c);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        vec_t vecs[7];
        int   ca, da, cb, db;
        int   len, ab;

        vecs[0] = '{len: 1, abort_c: -1, caps_a: 1, done_a: 7,  caps_b: 1, done_b: 6};
        vecs[1] = '{len: 3, abort_c: -1, caps_a: 3, done_a: 19, caps_b: 3, done_b: 16};
        vecs[2] = '{len: 0, abort_c: -1, caps_a: 0, done_a: 1,  caps_b: 0, done_b: 1};
        vecs[3] = '{len: 1, abort_c: 4,  caps_a: 0, done_a: -1, caps_b: 0, done_b: -1};
        vecs[4] = '{len: 1, abort_c: -1, caps_a: 1, done_a: 7,  caps_b: 1, done_b: 6};
        vecs[5] = '{len: 2, abort_c: 8,  caps_a: 1, done_a: -1, caps_b: 1, done_b: -1};
        vecs[6] = '{len: 5, abort_c: -1, caps_a: 5, done_a: 31, caps_b: 5, done_b: 26};

        // reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_obs("reset_a", 0, oa, '0, 1'b1);
        check_obs("reset_b", 0, ob, '0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // scenario table
        for (int i = 0; i < 7; i++) begin
            run_scen(vecs[i].len, vecs[i].abort_c, (i % 2) == 1, ca, da, cb, db);
            check_val($sformatf("caps_a[%0d]", i), ca, vecs[i].caps_a);
            check_val($sformatf("done_a[%0d]", i), da, vecs[i].done_a);
            check_val($sformatf("caps_b[%0d]", i), cb, vecs[i].caps_b);
            check_val($sformatf("done_b[%0d]", i), db, vecs[i].done_b);
        end

        // reset in the middle of a running sequence
        start   = 1'b1;
        seq_len = 8'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_val("busy_before_reset_a", int'(oa.busy), 1);
        check_val("busy_before_reset_b", int'(ob.busy), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_obs("mid_reset_a", 4, oa, '0, 1'b1);
        check_obs("mid_reset_b", 4, ob, '0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_obs("after_reset_a", 5, oa, '0, 1'b1);
        check_obs("after_reset_b", 5, ob, '0, 1'b1);

        // randomized sequences against the timeline model
        for (int i = 0; i < 25; i++) begin
            len = $urandom_range(0, 5);
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : -1;
            run_scen(len, ab, 1'b1, ca, da, cb, db);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
